// File: rtl/uart_fifo_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_fifo_core : UART with TX/RX FIFOs, parity, loopback, sticky errors  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+

module uart_fifo_core_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8,
  parameter int LW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata,
  output logic [LW-1:0] level,
  output logic          full,
  output logic          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == LW'(DEPTH));
  assign do_pop  = pop & ~empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the push.
  assign do_push = push & (~full | do_pop);
  assign level   = count;
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end
endmodule

module uart_fifo_core #(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [15:0]          divisor,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 loopback,
  input  logic                 tx_wr,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 rx_rd,
  input  logic                 clr_err,
  input  logic                 ie_rx,
  input  logic                 ie_tx,
  input  logic                 rxd,
  output logic                 txd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 dv,
  output logic                 thre,
  output logic                 tx_idle,
  output logic                 tx_full,
  output logic [LW-1:0]        tx_level,
  output logic [LW-1:0]        rx_level,
  output logic                 par_err,
  output logic                 frm_err,
  output logic                 ovr_err,
  output logic                 irq
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [15:0] div_eff;
  assign div_eff = (divisor < 16'd4) ? 16'd4 : divisor;

  // ---------------- transmitter ----------------
  state_t                 tx_state;
  logic [15:0]            tx_cnt;
  logic [15:0]            tx_div;
  logic [DATA_BITS-1:0]   tx_sh;
  logic [2:0]             tx_bit;
  logic                   tx_par_en;
  logic                   tx_par_bit;
  logic                   tx_line;
  logic [DATA_BITS-1:0]   tx_head;
  logic                   tx_empty;
  logic                   tx_end;
  logic                   tx_pop;

  assign tx_end = (tx_cnt == tx_div - 16'd1);
  assign tx_pop = ~tx_empty & ((tx_state == S_IDLE) | ((tx_state == S_STOP) & tx_end));

  uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_wr),
    .pop   (tx_pop),
    .wdata (tx_data),
    .rdata (tx_head),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  // Divisor and parity mode are captured when a frame starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state   <= S_IDLE;
      tx_cnt     <= '0;
      tx_div     <= 16'd4;
      tx_sh      <= '0;
      tx_bit     <= '0;
      tx_par_en  <= 1'b0;
      tx_par_bit <= 1'b0;
      tx_line    <= 1'b1;
    end else if (tx_pop) begin
      tx_state   <= S_START;
      tx_cnt     <= '0;
      tx_div     <= div_eff;
      tx_sh      <= tx_head;
      tx_par_en  <= par_en;
      tx_par_bit <= par_odd ^ (^tx_head);
      tx_line    <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: tx_line <= 1'b1;
        S_START: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            tx_state <= S_DATA;
            tx_bit   <= '0;
            tx_line  <= tx_sh[0];
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        S_DATA: begin
          if (tx_end) begin
            tx_cnt <= '0;
            if (tx_bit == 3'(DATA_BITS - 1)) begin
              tx_state <= tx_par_en ? S_PARITY : S_STOP;
              tx_line  <= tx_par_en ? tx_par_bit : 1'b1;
            end else begin
              tx_bit  <= tx_bit + 3'd1;
              tx_sh   <= tx_sh >> 1;
              tx_line <= tx_sh[1];
            end
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        S_PARITY: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            tx_state <= S_STOP;
            tx_line  <= 1'b1;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        S_STOP: begin
          if (tx_end) begin
            tx_cnt   <= '0;
            tx_state <= S_IDLE;
          end else tx_cnt <= tx_cnt + 16'd1;
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  assign txd     = loopback ? 1'b1 : tx_line;
  assign thre    = tx_empty;
  assign tx_idle = tx_empty & (tx_state == S_IDLE);

  // ---------------- receiver ----------------
  state_t                 rx_state;
  logic                   sync1;
  logic                   sync2;
  logic                   sync3;
  logic [15:0]            rx_cnt;
  logic [15:0]            rx_div;
  logic [DATA_BITS-1:0]   rx_sh;
  logic [2:0]             rx_bit;
  logic                   rx_par_en;
  logic                   rx_par_odd;
  logic                   rx_par_bad;
  logic                   rx_push;
  logic [DATA_BITS-1:0]   rx_word;
  logic                   frm_evt;
  logic                   par_evt;
  logic                   ovr_evt;
  logic                   rx_full;
  logic                   rx_empty;
  logic                   rx_end;
  logic                   rx_mid;
  logic                   fall;

  assign fall   = sync3 & ~sync2;
  assign rx_end = (rx_cnt == rx_div - 16'd1);
  assign rx_mid = (rx_cnt == (rx_div >> 1) - 16'd1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      sync3 <= 1'b1;
    end else begin
      sync1 <= loopback ? tx_line : rxd;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state   <= S_IDLE;
      rx_cnt     <= '0;
      rx_div     <= 16'd4;
      rx_sh      <= '0;
      rx_bit     <= '0;
      rx_par_en  <= 1'b0;
      rx_par_odd <= 1'b0;
      rx_par_bad <= 1'b0;
      rx_push    <= 1'b0;
      rx_word    <= '0;
      frm_evt    <= 1'b0;
      par_evt    <= 1'b0;
    end else begin
      rx_push <= 1'b0;
      frm_evt <= 1'b0;
      par_evt <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (fall) begin
            rx_state   <= S_START;
            rx_cnt     <= '0;
            rx_div     <= div_eff;
            rx_par_en  <= par_en;
            rx_par_odd <= par_odd;
            rx_par_bad <= 1'b0;
          end
        end
        S_START: begin
          if (rx_mid) begin
            rx_cnt   <= '0;
            rx_bit   <= '0;
            // A line back high at mid-start was a glitch, not a frame.
            rx_state <= sync2 ? S_IDLE : S_DATA;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        S_DATA: begin
          if (rx_end) begin
            rx_cnt <= '0;
            rx_sh  <= {sync2, rx_sh[DATA_BITS-1:1]};
            if (rx_bit == 3'(DATA_BITS - 1)) rx_state <= rx_par_en ? S_PARITY : S_STOP;
            else                             rx_bit   <= rx_bit + 3'd1;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        S_PARITY: begin
          if (rx_end) begin
            rx_cnt     <= '0;
            rx_par_bad <= sync2 != (rx_par_odd ^ (^rx_sh));
            rx_state   <= S_STOP;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        S_STOP: begin
          if (rx_end) begin
            rx_cnt   <= '0;
            rx_state <= S_IDLE;
            rx_push  <= 1'b1;
            rx_word  <= rx_sh;
            frm_evt  <= ~sync2;
            par_evt  <= rx_par_en & rx_par_bad;
          end else rx_cnt <= rx_cnt + 16'd1;
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

  uart_fifo_core_fifo #(.W(DATA_BITS), .DEPTH(FIFO_DEPTH), .LW(LW)) u_rx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (rx_push),
    .pop   (rx_rd),
    .wdata (rx_word),
    .rdata (rx_data),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

  assign dv      = ~rx_empty;
  assign ovr_evt = rx_push & rx_full & ~rx_rd;

  // Set wins over clear when an error lands in the clearing cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_err <= 1'b0;
      frm_err <= 1'b0;
      ovr_err <= 1'b0;
      irq     <= 1'b0;
    end else begin
      par_err <= (par_err & ~clr_err) | par_evt;
      frm_err <= (frm_err & ~clr_err) | frm_evt;
      ovr_err <= (ovr_err & ~clr_err) | ovr_evt;
      irq     <= (dv & ie_rx) | (thre & ie_tx);
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_uart_fifo_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_fifo_core : bench for uart_fifo_core against a frame-level model |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_uart_fifo_core;
  localparam int DB = 8;
  localparam int D  = 8;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [15:0]   divisor = 16'd4;
  logic          par_en = 1'b0, par_odd = 1'b0, loopback = 1'b0;
  logic          tx_wr = 1'b0;
  logic [DB-1:0] tx_data = '0;
  logic          rx_rd = 1'b0, clr_err = 1'b0, ie_rx = 1'b0, ie_tx = 1'b0;
  logic          rxd = 1'b1;
  logic          txd, dv, thre, tx_idle, tx_full, par_err, frm_err, ovr_err, irq;
  logic [DB-1:0] rx_data;
  logic [LW-1:0] tx_level, rx_level;

  uart_fifo_core #(.DATA_BITS(DB), .FIFO_DEPTH(D), .LW(LW)) dut (
    .clk(clk), .reset(reset), .divisor(divisor), .par_en(par_en), .par_odd(par_odd),
    .loopback(loopback), .tx_wr(tx_wr), .tx_data(tx_data), .rx_rd(rx_rd),
    .clr_err(clr_err), .ie_rx(ie_rx), .ie_tx(ie_tx), .rxd(rxd), .txd(txd),
    .rx_data(rx_data), .dv(dv), .thre(thre), .tx_idle(tx_idle), .tx_full(tx_full),
    .tx_level(tx_level), .rx_level(rx_level), .par_err(par_err), .frm_err(frm_err),
    .ovr_err(ovr_err), .irq(irq)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int eff(input logic [15:0] d);
    return (d < 16'd4) ? 4 : int'(d);
  endfunction

  // ---------------- behavioural model ----------------
  logic [DB-1:0] q_tx[$];
  logic [DB-1:0] q_rx[$];
  logic          model_ok = 1'b0;
  logic          mline = 1'b1;
  int            busy, rem, fdiv, fN;
  logic [DB-1:0] fdata;
  logic          fpen, fpb;
  logic          hist[4];
  logic          rx_act, rx_pen, rx_podd, rx_pbad;
  int            rx_t, rx_d;
  logic [DB-1:0] rx_bits;
  logic          pend, pend_frm, pend_par;
  logic [DB-1:0] pend_data;
  logic          m_par, m_frm, m_ovr, m_irq;

  always @(posedge clk) begin
    if (reset) begin
      q_tx.delete(); q_rx.delete();
      busy = 0; rem = 0; fdiv = 4; fN = DB + 2; fdata = '0; fpen = 0; fpb = 0;
      mline = 1'b1;
      for (int i = 0; i < 4; i++) hist[i] = 1'b1;
      rx_act = 0; rx_t = 0; rx_d = 4; rx_pen = 0; rx_podd = 0; rx_pbad = 0; rx_bits = '0;
      pend = 0; pend_frm = 0; pend_par = 0; pend_data = '0;
      m_par = 0; m_frm = 0; m_ovr = 0; m_irq = 0;
      model_ok = 1'b1;
    end else begin : step_model
      logic v, smp, ovr_e, start;
      int h, idx, el, b;
      v = loopback ? mline : rxd;
      m_irq = ((q_rx.size() != 0) & ie_rx) | ((q_tx.size() == 0) & ie_tx);
      // RX FIFO: pop first so a full FIFO can take a same-cycle write
      if (rx_rd && q_rx.size() != 0) void'(q_rx.pop_front());
      ovr_e = 0;
      if (pend) begin
        if (q_rx.size() < D) q_rx.push_back(pend_data);
        else ovr_e = 1;
      end
      m_par = (m_par & ~clr_err) | (pend & pend_par);
      m_frm = (m_frm & ~clr_err) | (pend & pend_frm);
      m_ovr = (m_ovr & ~clr_err) | ovr_e;
      pend = 0;
      // line value seen two flops late; sample points from the start edge
      hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = v;
      if (!rx_act) begin
        if (hist[3] && !hist[2]) begin
          rx_act = 1; rx_t = 0; rx_d = eff(divisor); rx_pen = par_en; rx_podd = par_odd; rx_pbad = 0;
        end
      end else begin
        rx_t++;
        smp = hist[2];
        h = rx_d / 2;
        if (rx_t == h) begin
          if (smp) rx_act = 0;
        end else if (rx_t > h && ((rx_t - h) % rx_d) == 0) begin
          idx = (rx_t - h) / rx_d;
          if (idx <= DB) rx_bits[idx-1] = smp;
          else if (idx == DB + 1 && rx_pen) rx_pbad = (smp != (rx_podd ^ (^rx_bits)));
          else begin
            pend = 1; pend_data = rx_bits; pend_frm = !smp; pend_par = rx_pen && rx_pbad; rx_act = 0;
          end
        end
      end
      // TX: a frame occupies fN*fdiv cycles; next one starts right after
      start = 0;
      if (busy != 0) begin
        rem--;
        if (rem == 0) begin busy = 0; start = (q_tx.size() != 0); end
      end else start = (q_tx.size() != 0);
      if (start) begin
        fdata = q_tx.pop_front();
        fdiv = eff(divisor); fpen = par_en; fpb = par_odd ^ (^fdata);
        fN = DB + 2 + (fpen ? 1 : 0);
        rem = fN * fdiv; busy = 1;
      end
      if (tx_wr && q_tx.size() < D) q_tx.push_back(tx_data);
      if (busy != 0) begin
        el = fN * fdiv - rem;
        b = el / fdiv;
        if (b == 0) mline = 1'b0;
        else if (b <= DB) mline = fdata[b-1];
        else if (b == DB + 1 && fpen) mline = fpb;
        else mline = 1'b1;
      end else mline = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!reset && model_ok) begin
      chk("txd", txd, loopback ? 1'b1 : mline);
      chk("tx_level", tx_level, q_tx.size());
      chk("rx_level", rx_level, q_rx.size());
      chk("dv", dv, q_rx.size() != 0);
      chk("thre", thre, q_tx.size() == 0);
      chk("tx_idle", tx_idle, (q_tx.size() == 0) && (busy == 0));
      chk("tx_full", tx_full, q_tx.size() == D);
      chk("rx_data", rx_data, (q_rx.size() != 0) ? q_rx[0] : 8'h00);
      chk("par_err", par_err, m_par);
      chk("frm_err", frm_err, m_frm);
      chk("ovr_err", ovr_err, m_ovr);
      chk("irq", irq, m_irq);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [DB-1:0] b);
    tx_wr = 1'b1; tx_data = b;
    step();
    tx_wr = 1'b0;
  endtask

  task automatic pop_rx();
    rx_rd = 1'b1;
    step();
    rx_rd = 1'b0;
  endtask

  task automatic clear_errs();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  task automatic wait_dv(input int budget, input string nm);
    int n = 0;
    while (!dv && n < budget) begin step(); n++; end
    chk(nm, dv, 1'b1);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input int bt);
    rxd = 1'b0; repeat (bt) step();
    for (int i = 0; i < DB; i++) begin rxd = d[i]; repeat (bt) step(); end
    if (par_en) begin rxd = pbit; repeat (bt) step(); end
    rxd = stop; repeat (bt) step();
    rxd = 1'b1; repeat (bt) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, t1, t2;
    repeat (3) step();
    chk("rst_txd", txd, 1'b1);
    chk("rst_dv", dv, 1'b0);
    chk("rst_thre", thre, 1'b1);
    chk("rst_tx_idle", tx_idle, 1'b1);
    chk("rst_tx_full", tx_full, 1'b0);
    chk("rst_levels", {tx_level, rx_level}, 8'h00);
    chk("rst_rx_data", rx_data, 8'h00);
    chk("rst_errs", {par_err, frm_err, ovr_err, irq}, 4'b0000);
    reset = 1'b0;
    step();

    // loopback single byte
    loopback = 1'b1; divisor = 16'd4; par_en = 1'b0; ie_rx = 1'b1;
    push(8'h55);
    wait_dv(46, "lb_dv_latency");
    chk("lb_data", rx_data, 8'h55);
    chk("lb_errs", {par_err, frm_err, ovr_err}, 3'b000);
    pop_rx();
    chk("lb_drained", dv, 1'b0);

    // external frame with wrong even parity, then a bad stop bit
    loopback = 1'b0; divisor = 16'd8; par_en = 1'b1; par_odd = 1'b0;
    send_frame(8'hA3, 1'b1, 1'b1, 8);
    wait_dv(20, "par_dv");
    chk("par_data", rx_data, 8'hA3);
    chk("par_flag", par_err, 1'b1);
    chk("par_no_frm", frm_err, 1'b0);
    clear_errs();
    chk("par_cleared", par_err, 1'b0);
    pop_rx();
    send_frame(8'h5A, 1'b0, 1'b0, 8);
    wait_dv(20, "frm_dv");
    chk("frm_data", rx_data, 8'h5A);
    chk("frm_flag", {frm_err, par_err}, 2'b10);
    pop_rx();
    clear_errs();

    // overrun: nine bytes into an eight-deep RX FIFO
    loopback = 1'b1; divisor = 16'd4; par_en = 1'b0;
    for (int i = 0; i < 9; i++) push(8'(i));
    c = 0;
    while (!tx_idle && c < 500) begin step(); c++; end
    repeat (10) step();
    chk("ovr_level", rx_level, 4'd8);
    chk("ovr_flag", ovr_err, 1'b1);
    for (int i = 0; i < 8; i++) begin
      chk("ovr_read", rx_data, 8'(i));
      pop_rx();
    end
    chk("ovr_empty", dv, 1'b0);
    clear_errs();

    // TX full with back-to-back frames
    loopback = 1'b0; ie_tx = 1'b1;
    for (int i = 0; i < 10; i++) push(8'hC0 + 8'(i));
    chk("txf_full", tx_full, 1'b1);
    chk("txf_level", tx_level, 4'd8);
    c = 0;
    while (!thre && c < 500) begin step(); c++; end
    t1 = c;
    while (!tx_idle && c < 1000) begin step(); c++; end
    t2 = c;
    chk("thre_to_idle", t2 - t1, 40);

    // one-cycle glitch on rxd
    rxd = 1'b0; step(); rxd = 1'b1;
    repeat (40) step();
    chk("glitch_level", rx_level, 4'd0);
    chk("glitch_errs", {par_err, frm_err, ovr_err}, 3'b000);

    // asynchronous reset mid-frame
    loopback = 1'b1; divisor = 16'd4;
    push(8'hAB);
    repeat (20) step();
    #1 reset = 1'b1;
    #1;
    chk("amid_rx_level", rx_level, 4'd0);
    chk("amid_txd", txd, 1'b1);
    chk("amid_tx_idle", tx_idle, 1'b1);
    step(); step();
    reset = 1'b0;
    step();
    push(8'h3C);
    wait_dv(50, "post_rst_dv");
    chk("post_rst_data", rx_data, 8'h3C);
    chk("post_rst_errs", {par_err, frm_err, ovr_err}, 3'b000);
    pop_rx();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) divisor = 16'($urandom_range(0, 9));
      if ($urandom_range(0, 49) == 0) par_en = 1'($urandom);
      if ($urandom_range(0, 49) == 0) par_odd = 1'($urandom);
      if ($urandom_range(0, 199) == 0) loopback = ~loopback;
      tx_wr = ($urandom_range(0, 5) == 0);
      tx_data = 8'($urandom);
      rx_rd = ($urandom_range(0, 3) == 0);
      clr_err = ($urandom_range(0, 39) == 0);
      ie_rx = 1'($urandom); ie_tx = 1'($urandom);
      if ($urandom_range(0, 5) == 0) rxd = ~rxd;
      step();
    end
    tx_wr = 1'b0; rx_rd = 1'b0; clr_err = 1'b0;
    repeat (5) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
